// File: rtl/data_memory.sv
// Single-port synchronous data memory for the CPU load/store path.
// One read and/or one write per clock, read-first on collision, registered read data.
module data_memory #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              data_mem_rd_enb,
  input  logic              data_mem_wr_enb,
  input  logic [ADDR_W-1:0] data_mem_addr,
  input  logic [DATA_W-1:0] data_mem_wr_data,
  output logic [DATA_W-1:0] data_mem_rd_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Flop array rather than a RAM macro: reset must clear every word in one edge.
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [DATA_W-1:0]            rd_data_q, rd_data_d;
  logic                         in_range;
  logic [IDX_W-1:0]             idx;

  always_comb begin
    in_range  = (32'(data_mem_addr) < DEPTH);
    idx       = data_mem_addr[IDX_W-1:0];
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    // Read samples mem_q, so a same-address write in this cycle is seen only next time.
    if (data_mem_rd_enb) begin
      rd_data_d = in_range ? mem_q[idx] : '0;
    end
    if (data_mem_wr_enb && in_range) begin
      mem_d[idx] = data_mem_wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q     <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign data_mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: full-depth instance plus a DEPTH=200 instance
// sharing the same stimulus to exercise out-of-range behaviour.
module tb_data_memory;

  logic       clock = 1'b0;
  logic       reset;
  logic       rd, wr;
  logic [7:0] addr, wdata;
  logic [7:0] rd_a, rd_b;

  int         n_run  = 0;
  int         n_fail = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  logic [7:0] e;

  always #5 clock = ~clock;

  data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(256)) dut_a (
    .clock(clock), .reset(reset),
    .data_mem_rd_enb(rd), .data_mem_wr_enb(wr),
    .data_mem_addr(addr), .data_mem_wr_data(wdata),
    .data_mem_rd_data(rd_a)
  );

  data_memory #(.DATA_W(8), .ADDR_W(8), .DEPTH(200)) dut_b (
    .clock(clock), .reset(reset),
    .data_mem_rd_enb(rd), .data_mem_wr_enb(wr),
    .data_mem_addr(addr), .data_mem_wr_data(wdata),
    .data_mem_rd_data(rd_b)
  );

  // Drive at negedge, let one rising edge sample, then settle for sampling.
  task automatic acc(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    acc(1'b1, 1'b1, 8'h44, 8'hEE);
    acc(1'b1, 1'b1, 8'h10, 8'hEE);
    exp_a.push_back(8'h00);
    exp_b.push_back(8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL reset_rd_a got=%h exp=%h", rd_a, e); end
    e = exp_b.pop_front(); n_run++;
    if (rd_b !== e) begin n_fail++; $display("FAIL reset_rd_b got=%h exp=%h", rd_b, e); end
    reset = 1'b0;
    // Writes attempted during reset must not have landed; never-written reads give 0.
    foreach (exp_a[i]) ;
    for (int k = 0; k < 2; k++) begin
      logic [7:0] a;
      a = (k == 0) ? 8'h44 : 8'h10;
      exp_a.push_back(8'h00);
      acc(1'b1, 1'b0, a, 8'h00);
      e = exp_a.pop_front(); n_run++;
      if (rd_a !== e) begin n_fail++; $display("FAIL reset_ignored_wr addr=%h got=%h exp=%h", a, rd_a, e); end
    end
  endtask

  task automatic test_reset_clear();
    acc(1'b0, 1'b1, 8'h10, 8'hA5);
    exp_a.push_back(8'hA5);
    acc(1'b1, 1'b0, 8'h10, 8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL clr_pre_rd got=%h exp=%h", rd_a, e); end
    reset = 1'b1;
    exp_a.push_back(8'h00);
    acc(1'b1, 1'b0, 8'h10, 8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL clr_during_reset got=%h exp=%h", rd_a, e); end
    reset = 1'b0;
    exp_a.push_back(8'h00);
    acc(1'b1, 1'b0, 8'h10, 8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL clr_post_rd got=%h exp=%h", rd_a, e); end
  endtask

  task automatic test_basic();
    logic [7:0] ra [2];
    logic [7:0] rv [2];
    ra[0] = 8'h00; rv[0] = 8'h3C;
    ra[1] = 8'hFF; rv[1] = 8'hFF;
    acc(1'b0, 1'b1, ra[0], rv[0]);
    acc(1'b0, 1'b1, ra[1], rv[1]);
    for (int k = 0; k < 2; k++) begin
      exp_a.push_back(rv[k]);
      acc(1'b1, 1'b0, ra[k], 8'h00);
      e = exp_a.pop_front(); n_run++;
      if (rd_a !== e) begin n_fail++; $display("FAIL basic_rd addr=%h got=%h exp=%h", ra[k], rd_a, e); end
    end
  endtask

  task automatic test_collision();
    acc(1'b0, 1'b1, 8'h20, 8'h11);
    exp_a.push_back(8'h11);
    acc(1'b1, 1'b1, 8'h20, 8'h22);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL collide_old got=%h exp=%h", rd_a, e); end
    exp_a.push_back(8'h22);
    acc(1'b1, 1'b0, 8'h20, 8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL collide_new got=%h exp=%h", rd_a, e); end
  endtask

  task automatic test_hold();
    acc(1'b0, 1'b1, 8'h05, 8'h77);
    exp_a.push_back(8'h77);
    acc(1'b1, 1'b0, 8'h05, 8'h00);
    e = exp_a.pop_front(); n_run++;
    if (rd_a !== e) begin n_fail++; $display("FAIL hold_rd got=%h exp=%h", rd_a, e); end
    for (int k = 0; k < 5; k++) begin
      exp_a.push_back(8'h77);
      acc(1'b0, 1'b1, 8'(8'h06 + k), 8'(8'h90 + k));
      e = exp_a.pop_front(); n_run++;
      if (rd_a !== e) begin n_fail++; $display("FAIL hold_cycle%0d got=%h exp=%h", k, rd_a, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 256; i++) acc(1'b0, 1'b1, 8'(i), ~8'(i));
    for (int i = 0; i < 256; i++) begin
      exp_a.push_back(~8'(i));
      exp_b.push_back((i < 200) ? ~8'(i) : 8'h00);
      acc(1'b1, 1'b0, 8'(i), 8'h00);
      e = exp_a.pop_front(); n_run++;
      if (rd_a !== e) begin n_fail++; $display("FAIL sweep_a addr=%0d got=%h exp=%h", i, rd_a, e); end
      e = exp_b.pop_front(); n_run++;
      if (rd_b !== e) begin n_fail++; $display("FAIL sweep_b addr=%0d got=%h exp=%h", i, rd_b, e); end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] ra [2];
    logic [7:0] ea [2];
    reset = 1'b1;
    acc(1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b0;
    acc(1'b0, 1'b1, 8'd210, 8'h55);
    ra[0] = 8'd210; ea[0] = 8'h55;
    ra[1] = 8'd10;  ea[1] = 8'h00;
    for (int k = 0; k < 2; k++) begin
      exp_a.push_back(ea[k]);
      exp_b.push_back(8'h00);
      acc(1'b1, 1'b0, ra[k], 8'h00);
      e = exp_a.pop_front(); n_run++;
      if (rd_a !== e) begin n_fail++; $display("FAIL oor_full addr=%0d got=%h exp=%h", ra[k], rd_a, e); end
      e = exp_b.pop_front(); n_run++;
      if (rd_b !== e) begin n_fail++; $display("FAIL oor_small addr=%0d got=%h exp=%h", ra[k], rd_b, e); end
    end
    // A stale nonzero value must be replaced by 0 on an out-of-range read.
    acc(1'b0, 1'b1, 8'd20, 8'h6B);
    exp_b.push_back(8'h6B);
    acc(1'b1, 1'b0, 8'd20, 8'h00);
    e = exp_b.pop_front(); n_run++;
    if (rd_b !== e) begin n_fail++; $display("FAIL oor_pre got=%h exp=%h", rd_b, e); end
    exp_b.push_back(8'h00);
    acc(1'b1, 1'b0, 8'd255, 8'h00);
    e = exp_b.pop_front(); n_run++;
    if (rd_b !== e) begin n_fail++; $display("FAIL oor_zero got=%h exp=%h", rd_b, e); end
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    test_reset();
    test_reset_clear();
    test_basic();
    test_collision();
    test_hold();
    test_back_to_back();
    test_out_of_range();
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_run++; n_fail++;
      $display("FAIL scoreboard_drain left_a=%0d left_b=%0d exp=0", exp_a.size(), exp_b.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
